// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit owning the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; fixed 33-edge latency.
module muldiv_unit (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        hilo_we_i,
    input  logic        hilo_sel_i,
    input  logic [31:0] hilo_wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_by_zero_o,
    output logic [31:0] hi_out_o,
    output logic [31:0] lo_out_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        is_div_q;
    logic        neg_lo_q;
    logic        neg_hi_q;
    logic        zero_div_q;
    logic [31:0] opnd_q;
    logic [31:0] raw_a_q;
    logic [63:0] acc_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;

    logic        sgn_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] acc_d;
    logic [63:0] prod_signed;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Operand capture: signed ops (op[0]=0) work on magnitudes and fix the sign at the end.
    always_comb begin
        sgn_op = ~op_i[0];
        mag_a  = abs32(operand_a_i, sgn_op);
        mag_b  = abs32(operand_b_i, sgn_op);
    end

    // One iteration. Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + ({33{acc_q[0]}} & {1'b0, opnd_q});
        div_ge   = (acc_q[63:31] >= {1'b0, opnd_q});
        div_diff = acc_q[62:31] - opnd_q;
        acc_d    = acc_q;
        if (is_div_q) begin
            if (div_ge) begin
                acc_d = {div_diff, acc_q[30:0], 1'b1};
            end else begin
                acc_d = {acc_q[62:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum, acc_q[31:1]};
        end
    end

    // Final sign correction and divide-by-zero override applied in FINISH.
    always_comb begin
        prod_signed = neg_lo_q ? (64'd0 - acc_q) : acc_q;
        quo_signed  = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_signed  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        hi_d        = prod_signed[63:32];
        lo_d        = prod_signed[31:0];
        if (is_div_q) begin
            if (zero_div_q) begin
                hi_d = raw_a_q;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                hi_d = rem_signed;
                lo_d = quo_signed;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            zero_div_q <= 1'b0;
            opnd_q     <= 32'd0;
            raw_a_q    <= 32'd0;
            acc_q      <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hilo_we_i) begin
                        if (hilo_sel_i) begin
                            hi_q <= hilo_wdata_i;
                        end else begin
                            lo_q <= hilo_wdata_i;
                        end
                    end
                    if (start_i) begin
                        is_div_q   <= op_i[1];
                        neg_lo_q   <= sgn_op & (operand_a_i[31] ^ operand_b_i[31]);
                        neg_hi_q   <= op_i[1] ? (sgn_op & operand_a_i[31])
                                              : (sgn_op & (operand_a_i[31] ^ operand_b_i[31]));
                        zero_div_q <= op_i[1] && (operand_b_i == 32'd0);
                        raw_a_q    <= operand_a_i;
                        opnd_q     <= op_i[1] ? mag_b : mag_a;
                        acc_q      <= {32'd0, (op_i[1] ? mag_a : mag_b)};
                        cnt_q      <= 6'd0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    dbz_q   <= zero_div_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_out_o      = hi_q;
    assign lo_out_o      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: table of ops run back-to-back plus
// hand-written sequences for start/MT-write interplay and mid-op reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start_r;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        hilo_we_r;
    logic        hilo_sel_r;
    logic [31:0] hilo_wdata_r;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs [16];

    muldiv_unit dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .start_i       (start_r),
        .op_i          (op_r),
        .operand_a_i   (a_r),
        .operand_b_i   (b_r),
        .hilo_we_i     (hilo_we_r),
        .hilo_sel_i    (hilo_sel_r),
        .hilo_wdata_i  (hilo_wdata_r),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz),
        .hi_out_o      (hi),
        .lo_out_o      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered at a negedge; leaves at the negedge where done is seen (or the bound expires).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dbz, input bit hold, input bit mt,
                          input logic [31:0] mt_data, input string tag);
        int n;
        int busy_cnt;
        logic [31:0] snap_hi;
        logic [31:0] snap_lo;
        bit stable;
        op_r    = op;
        a_r     = a;
        b_r     = b;
        start_r = 1'b1;
        if (mt) begin
            hilo_we_r    = 1'b1;
            hilo_sel_r   = 1'b1;
            hilo_wdata_r = mt_data;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_r = 1'b0;
        hilo_we_r = 1'b0;
        chk({tag, "_prev_done_low"}, {63'd0, done}, 64'd0);
        chk({tag, "_prev_dbz_low"}, {63'd0, dbz}, 64'd0);
        if (mt) chk({tag, "_mt_first"}, {32'd0, hi}, {32'd0, mt_data});
        snap_hi  = hi;
        snap_lo  = lo;
        stable   = 1'b1;
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 60) begin
            if (busy) busy_cnt++;
            if (hi !== snap_hi || lo !== snap_lo) stable = 1'b0;
            if (hold) begin
                a_r          = $urandom;
                b_r          = $urandom;
                hilo_we_r    = n[0];
                hilo_sel_r   = n[1];
                hilo_wdata_r = $urandom;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start_r   = 1'b0;
        hilo_we_r = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({tag, "_busy_low_at_done"}, {63'd0, busy}, 64'd0);
        chk({tag, "_hilo_stable"}, {63'd0, stable}, 64'd1);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        chk({tag, "_dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
        $display("op %s: op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b latency=%0d",
                 tag, op, a, b, hi, lo, dbz, n);
    endtask

    // Entered at a negedge; MT write lands at the next edge.
    task automatic mt_write(input logic sel, input logic [31:0] data, input string tag);
        hilo_we_r    = 1'b1;
        hilo_sel_r   = sel;
        hilo_wdata_r = data;
        @(posedge clk);
        @(negedge clk);
        hilo_we_r = 1'b0;
        if (sel) chk({tag, "_hi"}, {32'd0, hi}, {32'd0, data});
        else     chk({tag, "_lo"}, {32'd0, lo}, {32'd0, data});
        $display("mt %s: sel=%0b data=0x%08h -> hi=0x%08h lo=0x%08h", tag, sel, data, hi, lo);
    endtask

    initial begin
        int done_seen;
        int busy_seen;
        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{OP_DIVU,  32'd11,        32'd5,         32'd1,         32'd2,         1'b0};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{OP_DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[8]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[9]  = '{OP_MULT,  32'h7FFF_FFFF, 32'd2,         32'h0000_0000, 32'hFFFF_FFFE, 1'b0};
        vecs[10] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[11] = '{OP_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0};
        vecs[12] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[13] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[14] = '{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[15] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};

        rst          = 1'b1;
        start_r      = 1'b0;
        op_r         = 2'b00;
        a_r          = 32'd0;
        b_r          = 32'd0;
        hilo_we_r    = 1'b0;
        hilo_sel_r   = 1'b0;
        hilo_wdata_r = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dbz", {63'd0, dbz}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table ops issued back-to-back: each new start is presented in the done cycle.
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   vecs[i].exp_dbz, 1'b0, 1'b0, 32'd0, $sformatf("vec%0d", i));
        end

        // start held high and MT writes toggled while busy: all ignored.
        run_op(OP_MULT, 32'd6, 32'd4, 32'd0, 32'd24, 1'b0, 1'b1, 1'b0, 32'd0, "hold_mult");
        @(posedge clk);
        @(negedge clk);
        chk("hold_no_restart_busy", {63'd0, busy}, 64'd0);
        chk("hold_done_pulse_1cyc", {63'd0, done}, 64'd0);
        mt_write(1'b1, 32'hA5A5_A5A5, "mthi_idle");
        chk("mthi_lo_kept", {32'd0, lo}, 64'd24);
        mt_write(1'b0, 32'h0000_005A, "mtlo_idle");

        // MT write accepted in the same cycle as start; the result later overwrites it.
        run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, "mt_and_start");
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset at iteration 10 of a DIVU.
        mt_write(1'b1, 32'h1111_1111, "mthi_pre_reset");
        start_r = 1'b1;
        op_r    = OP_DIVU;
        a_r     = 32'd100;
        b_r     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start_r = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_busy", {63'd0, busy}, 64'd0);
        chk("async_reset_done", {63'd0, done}, 64'd0);
        chk("async_reset_hi", {32'd0, hi}, 64'd0);
        chk("async_reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        chk("no_done_after_abort", 64'(done_seen), 64'd0);
        chk("no_busy_after_abort", 64'(busy_seen), 64'd0);
        run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0, 1'b0, 32'd0, "post_reset_multu");
        @(posedge clk);
        @(negedge clk);
        chk("final_done_pulse_1cyc", {63'd0, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS32 core, sitting directly downstream of the register file: it consumes the two read operands (rs, rt) and owns the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU with a fixed 33-cycle latency. It supports MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO results, which then return to the register file write port.

## Interface
Parameters:
- none; datapath fixed at 32 bits, iteration count fixed at 32.

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request a new operation; sampled only when busy=0
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  in  32  rs value (register file ReadData1): multiplicand / dividend
- operand_b  in  32  rt value (register file ReadData2): multiplier / divisor
- hilo_we  in  1  MTHI/MTLO write enable
- hilo_sel  in  1  0 = write LO, 1 = write HI
- hilo_wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress; upstream stalls MF*/MT*/mul/div while high
- done  out  1  one-cycle pulse when HI/LO hold the new result
- div_by_zero  out  1  high with done when a DIV/DIVU had operand_b = 0; else 0
- hi_out  out  32  current HI register
- lo_out  out  32  current LO register

## Operation
- Reset values: busy=0, done=0, div_by_zero=0, hi_out=0, lo_out=0, state IDLE, iteration counter 0.
- States:
  - IDLE: start=1 latches op, operand magnitudes and result sign, clears counter, and moves to RUN. Signed ops take absolute values, with sign handling only for 00/10.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. The counter increments each cycle, and the unit moves to FINISH after the 32nd step.
  - FINISH: applies sign correction, writes HI/LO, pulses done, and returns to IDLE.
- MULT/MULTU: the full 64-bit product is written; HI = bits 63:32 and LO = bits 31:0.
- DIV/DIVU: LO = quotient and HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0. This is 32-bit wrap with no trap.
- Divide by zero: full latency still applies. The result is HI=operand_a (as latched), LO=0xFFFFFFFF, and div_by_zero=1 during the done cycle.
- start while busy=1 is ignored and has no effect on the running op.
- hilo_we is honoured only when busy=0; it is ignored while busy.
  - If hilo_we and an accepted start occur in the same cycle, the MT write lands first and the op result later overwrites HI/LO.
- hi_out/lo_out change only on reset, an accepted hilo_we, or FINISH. Intermediate RUN state is never visible on them.
- Asynchronous reset mid-operation aborts immediately: HI/LO are cleared, no done pulse is issued, and the unit is ready to accept start on the first edge after reset deasserts.

## Timing
- Edge E0: start sampled with busy=0. busy rises after E0.
- E1–E32: 32 RUN iterations.
- E33: FINISH. HI/LO are updated, done=1, and busy=0 in the cycle following E33.
- done is high for exactly one cycle. A new start may be presented in that same cycle and is accepted at the next edge, so back-to-back ops run 34 cycles apart.
- Latency from start edge to valid HI/LO is 33 edges for every op, including divide by zero.
- busy is high for exactly 33 cycles per op.
- An MT write is visible on hi_out/lo_out the cycle after its edge.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (-3), b=7 -> after 33 edges done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then DIVU a=11, b=5 -> LO=2, HI=1, div_by_zero=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV a=0x12345678, b=0 -> done after 33 edges with div_by_zero=1, HI=0x12345678, LO=0xFFFFFFFF; div_by_zero returns to 0 the next cycle.
- Hold start high and toggle operands and hilo_we during a running MULT 6×4 -> the second start and the MT writes are ignored, and the result is HI=0, LO=24.
  - Then hilo_we=1, sel=1, data=0xA5A5A5A5 while idle -> hi_out=0xA5A5A5A5 next cycle.
- Assert reset at iteration 10 of a DIVU -> busy, done, HI and LO are 0 immediately with no done pulse; a fresh MULTU 3×5 then gives LO=15, HI=0.
